// File: rtl/score4_pkg.sv
// Shared score4 types and board geometry, used by win_scan, state_update and the VGA renderer.
package score4_pkg;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int LINE = 4;

  typedef enum logic [1:0] {EMPTY = 2'b00, RED = 2'b01, YELLOW = 2'b10} cell_t;
  typedef enum logic [1:0] {H = 2'd0, V = 2'd1, DR = 2'd2, DL = 2'd3} dir_t;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_state_t;

  // 2'b11 is not a legal player code and counts as an empty cell
  function automatic logic cell_empty(input logic [1:0] c);
    return (c == 2'b00) || (c == 2'b11);
  endfunction

endpackage

// File: rtl/win_scan_line_match.sv
// Combinational run detector: all LINE cells of a window hold the given player code.
module line_match #(
  parameter int LINE = 4
) (
  input  logic [LINE-1:0][1:0] cells,
  input  logic [1:0]           player,
  output logic                 match
);

  always_comb begin
    match = 1'b1;
    for (int k = 0; k < LINE; k++)
      if (cells[k] != player) match = 1'b0;
  end

endmodule

// File: rtl/win_scan.sv
// Sequential score4 win/full detector: scans a board snapshot one anchor cell per cycle
// and checks the four line directions from each anchor.
module win_scan #(
  parameter int ROWS = 6,
  parameter int COLS = 7,
  parameter int LINE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ROWS-1:0][COLS-1:0][1:0]    panel,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              win_a,
  output logic                              win_b,
  output logic                              full_panel,
  output logic                              win_valid,
  output logic [$clog2(ROWS)-1:0]           win_row,
  output logic [$clog2(COLS)-1:0]           win_col,
  output logic [1:0]                        win_dir
);
  import score4_pkg::*;

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int NDIR = 4;

  scan_state_t state, state_nxt;

  logic [ROWS-1:0][COLS-1:0][1:0] snap;
  logic [RW-1:0] row, pend_row, pend_row_nxt;
  logic [CW-1:0] col, pend_col, pend_col_nxt;
  logic [1:0]    pend_dir, pend_dir_nxt, first_dir;
  logic          a_hit, b_hit, first_hit, empty_seen;
  logic          a_nxt, b_nxt, empty_nxt, last_cell;

  logic [NDIR-1:0][LINE-1:0][1:0] win_cells;
  logic [NDIR-1:0] inb, hit_a, hit_b, any_hit;

  assign last_cell = (int'(row) == ROWS-1) && (int'(col) == COLS-1);

  // Windows never wrap: a direction is only considered when its whole line fits on the board
  assign inb[H]  = int'(col) <= COLS-LINE;
  assign inb[V]  = int'(row) <= ROWS-LINE;
  assign inb[DR] = (int'(row) <= ROWS-LINE) && (int'(col) <= COLS-LINE);
  assign inb[DL] = (int'(row) <= ROWS-LINE) && (int'(col) >= LINE-1);

  for (genvar d = 0; d < NDIR; d++) begin : g_dir
    localparam int DRO = (d == 0) ? 0 : 1;
    localparam int DCO = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;

    for (genvar k = 0; k < LINE; k++) begin : g_cell
      always_comb begin : fetch
        int r, c;
        r = int'(row) + DRO*k;
        c = int'(col) + DCO*k;
        win_cells[d][k] = 2'b00;
        if (r >= 0 && r < ROWS && c >= 0 && c < COLS)
          win_cells[d][k] = snap[r[RW-1:0]][c[CW-1:0]];
      end
    end

    line_match #(.LINE(LINE)) u_match_a (.cells(win_cells[d]), .player(RED),    .match(hit_a[d]));
    line_match #(.LINE(LINE)) u_match_b (.cells(win_cells[d]), .player(YELLOW), .match(hit_b[d]));

    assign any_hit[d] = inb[d] & (hit_a[d] | hit_b[d]);
  end

  always_comb begin
    a_nxt     = a_hit | |(hit_a & inb);
    b_nxt     = b_hit | |(hit_b & inb);
    empty_nxt = empty_seen | cell_empty(snap[row][col]);
    first_dir = 2'd0;
    for (int d = NDIR-1; d >= 0; d--)
      if (any_hit[d]) first_dir = 2'(d);
    pend_row_nxt = pend_row;
    pend_col_nxt = pend_col;
    pend_dir_nxt = pend_dir;
    if (!first_hit && |any_hit) begin
      pend_row_nxt = row;
      pend_col_nxt = col;
      pend_dir_nxt = first_dir;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_SCAN;
      S_SCAN: begin
        busy = 1'b1;
        if (last_cell) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result registers load on the edge into DONE so they are already visible with the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap       <= '0;
      row        <= '0;
      col        <= '0;
      a_hit      <= 1'b0;
      b_hit      <= 1'b0;
      first_hit  <= 1'b0;
      empty_seen <= 1'b0;
      pend_row   <= '0;
      pend_col   <= '0;
      pend_dir   <= '0;
      win_a      <= 1'b0;
      win_b      <= 1'b0;
      full_panel <= 1'b0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      win_dir    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          snap       <= panel;
          row        <= '0;
          col        <= '0;
          a_hit      <= 1'b0;
          b_hit      <= 1'b0;
          first_hit  <= 1'b0;
          empty_seen <= 1'b0;
          pend_row   <= '0;
          pend_col   <= '0;
          pend_dir   <= '0;
        end
        S_SCAN: begin
          a_hit      <= a_nxt;
          b_hit      <= b_nxt;
          empty_seen <= empty_nxt;
          first_hit  <= first_hit | |any_hit;
          pend_row   <= pend_row_nxt;
          pend_col   <= pend_col_nxt;
          pend_dir   <= pend_dir_nxt;
          if (int'(col) == COLS-1) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
          if (last_cell) begin
            win_a      <= a_nxt;
            win_b      <= b_nxt;
            full_panel <= ~empty_nxt;
            win_valid  <= a_nxt | b_nxt;
            win_row    <= pend_row_nxt;
            win_col    <= pend_col_nxt;
            win_dir    <= pend_dir_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_win_scan.sv
// Directed bench for win_scan: stimulus pushes expected results, a monitor checks each done pulse.
module tb_win_scan;

  localparam logic [1:0] E = 2'b00, R = 2'b01, Y = 2'b10, X = 2'b11;
  localparam logic [1:0] DH = 2'd0, DV = 2'd1, DDR = 2'd2, DDL = 2'd3;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [5:0][6:0][1:0] panel = '0;
  logic busy, done, win_a, win_b, full_panel, win_valid;
  logic [2:0] win_row, win_col;
  logic [1:0] win_dir;

  win_scan #(.ROWS(6), .COLS(7), .LINE(4)) dut (
    .clk(clk), .rst(rst), .panel(panel), .start(start), .busy(busy), .done(done),
    .win_a(win_a), .win_b(win_b), .full_panel(full_panel), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col), .win_dir(win_dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] res;
    int          issue;
  } exp_t;

  exp_t q[$];
  logic [5:0][6:0][1:0] bp;
  int cyc = 0, nchk = 0, nfail = 0, done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] pk(input logic wa, input logic wb, input logic full,
                                     input logic vld, input logic [2:0] r, input logic [2:0] c,
                                     input logic [1:0] d);
    return {wa, wb, full, vld, r, c, d};
  endfunction

  task automatic put(input logic [2:0] r, input logic [2:0] c, input logic [1:0] v);
    bp[r][c] = v;
  endtask

  // Checkerboard of column pairs: no run longer than 2 in any direction
  task automatic fill_norun();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        bp[3'(r)][3'(c)] = ((((c >> 1) + r) & 1) != 0) ? Y : R;
  endtask

  task automatic issue(input logic [11:0] res);
    exp_t e;
    @(negedge clk);
    panel   = bp;
    start   = 1'b1;
    e.res   = res;
    e.issue = cyc;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 80; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      nchk++;
      nfail++;
      $display("FAIL done_timeout: got no done pulse, expected one within 80 cycles");
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [11:0] res);
    issue(res);
    wait_empty();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        done_cnt++;
        if (q.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_done: got done pulse at cycle %0d, expected none", cyc);
        end else begin
          e = q.pop_front();
          chk("latency", cyc - e.issue, 43);
          chk("result", {win_a, win_b, full_panel, win_valid, win_row, win_col, win_dir}, e.res);
          chk("busy_at_done", busy, 1);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int d0;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, win_a, win_b, full_panel, win_valid, win_row, win_col, win_dir}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1 empty board
    bp = '0;
    run(pk(0, 0, 0, 0, 0, 0, DH));

    // 2 red horizontal at the right edge of row 0
    bp = '0;
    for (int c = 3; c < 7; c++) put(0, 3'(c), R);
    run(pk(1, 0, 0, 1, 0, 3, DH));

    // 3 yellow vertical at the top of col 0, yellow anti-diagonal
    bp = '0;
    for (int r = 2; r < 6; r++) put(3'(r), 0, Y);
    run(pk(0, 1, 0, 1, 2, 0, DV));
    bp = '0;
    put(0, 3, Y); put(1, 2, Y); put(2, 1, Y); put(3, 0, Y);
    run(pk(0, 1, 0, 1, 0, 3, DDL));

    // red diagonal, and H beats V from the same anchor
    bp = '0;
    for (int k = 1; k < 5; k++) put(3'(k), 3'(k), R);
    run(pk(1, 0, 0, 1, 1, 1, DDR));
    bp = '0;
    for (int k = 0; k < 4; k++) begin put(0, 3'(k), R); put(3'(k), 0, R); end
    run(pk(1, 0, 0, 1, 0, 0, DH));

    // 4 no wrap across rows, no 3-run win, 11 cells count as empty
    bp = '0;
    put(0, 5, R); put(0, 6, R); put(1, 0, R); put(1, 1, R);
    run(pk(0, 0, 0, 0, 0, 0, DH));
    bp = '0;
    put(2, 6, R); put(3, 6, R); put(4, 6, R);
    run(pk(0, 0, 0, 0, 0, 0, DH));
    bp = {42{X}};
    run(pk(0, 0, 0, 0, 0, 0, DH));

    // both players: earliest line reported; last in-bounds H anchor
    bp = '0;
    for (int c = 0; c < 4; c++) begin put(1, 3'(c), Y); put(2, 3'(c), R); end
    run(pk(1, 1, 0, 1, 1, 0, DH));
    bp = '0;
    for (int c = 3; c < 7; c++) put(5, 3'(c), Y);
    run(pk(0, 1, 0, 1, 5, 3, DH));

    // 5 full board without / with a win
    fill_norun();
    run(pk(0, 0, 1, 0, 0, 0, DH));
    for (int c = 0; c < 4; c++) put(5, 3'(c), R);
    run(pk(1, 0, 1, 1, 5, 0, DH));

    // 6 start while busy is ignored, panel changes mid-scan do not matter
    d0 = done_cnt;
    bp = '0;
    issue(pk(0, 0, 0, 0, 0, 0, DH));
    repeat (10) @(negedge clk);
    for (int c = 0; c < 4; c++) panel[0][c] = R;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
    repeat (50) @(negedge clk);
    chk("one_done_per_start", done_cnt - d0, 1);

    // reset in cycle 20 of a winning scan, after a winning result is held
    bp = '0;
    for (int c = 0; c < 4; c++) put(0, 3'(c), Y);
    run(pk(0, 1, 0, 1, 0, 0, DH));
    issue(pk(0, 1, 0, 1, 0, 0, DH));
    repeat (18) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_abort", {busy, done, win_a, win_b, full_panel, win_valid, win_row, win_col, win_dir}, 0);
    q.delete();
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("no_done_after_rst", done_cnt - d0, 0);
    chk("held_after_rst", {win_a, win_b, win_valid}, 0);
    run(pk(0, 1, 0, 1, 0, 0, DH));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
